// File: rtl/ysyx_22041211_lsu_pkg.sv
// ----------------------------------------------------------------------------
// ysyx_22041211_lsu_pkg
// Shared definitions for the LSU/writeback stage of the NPC core.
//   - LSU_DATA_WIDTH : default datapath width (only 32 is supported)
//   - F3_*           : funct3 encodings for loads and stores
//   - lsu_state_e    : LSU/WB FSM state encoding
//   - access_fault   : illegal-funct3 / misalignment detection
//   - store_wdata    : lane-replicated store data
//   - store_wstrb    : byte strobes for a store
// ----------------------------------------------------------------------------
package ysyx_22041211_lsu_pkg;

    localparam int LSU_DATA_WIDTH = 32;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_WB   = 2'd3
    } lsu_state_e;

    // Access size lives in funct3[1:0] for both loads and stores, so the
    // alignment test is shared; legality differs between the two.
    function automatic logic access_fault(input logic       is_load,
                                          input logic       is_store,
                                          input logic [2:0] funct3,
                                          input logic [1:0] off);
        logic legal;
        logic misaligned;
        legal = 1'b1;
        if (is_load) begin
            legal = (funct3 == F3_LB) || (funct3 == F3_LH) || (funct3 == F3_LW) ||
                    (funct3 == F3_LBU) || (funct3 == F3_LHU);
        end else if (is_store) begin
            legal = (funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW);
        end
        misaligned = ((funct3[1:0] == 2'b01) && off[0]) ||
                     ((funct3[1:0] == 2'b10) && (off != 2'b00));
        return (is_load || is_store) && (!legal || misaligned);
    endfunction

    // Replicating the byte/half into every lane lets memory pick it up with
    // the strobes alone, without knowing the offset.
    function automatic logic [31:0] store_wdata(input logic [2:0]  funct3,
                                                input logic [31:0] data);
        case (funct3)
            F3_SB:   return {4{data[7:0]}};
            F3_SH:   return {2{data[15:0]}};
            default: return data;
        endcase
    endfunction

    function automatic logic [3:0] store_wstrb(input logic [2:0] funct3,
                                               input logic [1:0] off);
        case (funct3)
            F3_SB:   return 4'b0001 << off;
            F3_SH:   return 4'b0011 << off;
            F3_SW:   return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_22041211_load_align.sv
// ----------------------------------------------------------------------------
// ysyx_22041211_load_align
// Combinational load-data alignment and extension.
//   i_rdata  : aligned 32-bit word returned by data memory
//   i_off    : byte offset of the access (address[1:0])
//   i_funct3 : load size/sign encoding
//   o_data   : value to write to the destination register
// ----------------------------------------------------------------------------
module ysyx_22041211_load_align
    import ysyx_22041211_lsu_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_off,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    logic [31:0] w_shifted;

    // Move the addressed byte/half down to bit 0 before extending.
    assign w_shifted = i_rdata >> {i_off, 3'b000};

    always_comb begin
        // NOTE: default assignment first so no path leaves o_data unassigned (no latch).
        o_data = w_shifted;
        case (i_funct3)
            F3_LB:   o_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
            F3_LH:   o_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            F3_LBU:  o_data = {24'd0, w_shifted[7:0]};
            F3_LHU:  o_data = {16'd0, w_shifted[15:0]};
            default: o_data = w_shifted;
        endcase
    end

endmodule

// File: rtl/ysyx_22041211_lsu_wb.sv
// ----------------------------------------------------------------------------
// ysyx_22041211_lsu_wb
// Memory-access and writeback stage. Accepts one instruction from the EXU,
// performs an optional load/store over a req/gnt/rvalid interface, and issues
// a one-cycle register-file write.
//   clk, rst                    : clock, asynchronous active-high reset
//   in_valid / in_ready         : EXU handshake
//   in_alu_result ... in_funct3 : executed instruction fields
//   mem_req/we/addr/wdata/wstrb : data-memory request (held until mem_gnt)
//   mem_gnt/rvalid/rdata        : data-memory responses
//   wb_en/wb_rd/wb_data         : register-file write port
//   lsu_fault                   : one-cycle pulse on illegal/misaligned access
// ----------------------------------------------------------------------------
module ysyx_22041211_lsu_wb
    import ysyx_22041211_lsu_pkg::*;
#(
    parameter int DATA_WIDTH = LSU_DATA_WIDTH,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_alu_result,
    input  logic [DATA_WIDTH-1:0] in_store_data,
    input  logic [4:0]            in_rd,
    input  logic                  in_reg_write,
    input  logic                  in_mem_read,
    input  logic                  in_mem_write,
    input  logic [2:0]            in_funct3,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [3:0]            mem_wstrb,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  wb_en,
    output logic [4:0]            wb_rd,
    output logic [DATA_WIDTH-1:0] wb_data,
    output logic                  lsu_fault
);

    lsu_state_e  r_state;
    logic [4:0]  r_rd;
    logic        r_reg_write;
    logic        r_is_store;
    logic [2:0]  r_funct3;
    logic [1:0]  r_off;

    logic        w_accept;
    logic        w_is_mem;
    logic        w_fault;
    logic        w_load_wb_en;
    logic [31:0] w_load_data;

    assign in_ready     = (r_state == ST_IDLE) && !rst;
    assign w_accept     = in_valid && in_ready;
    assign w_is_mem     = in_mem_read || in_mem_write;
    assign w_fault      = access_fault(in_mem_read, in_mem_write, in_funct3, in_alu_result[1:0]);
    // Writes to x0 are suppressed here so the register file never sees them.
    assign w_load_wb_en = r_reg_write && (r_rd != 5'd0);

    ysyx_22041211_load_align u_load_align (
        .i_rdata  (mem_rdata),
        .i_off    (r_off),
        .i_funct3 (r_funct3),
        .o_data   (w_load_data)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_rd        <= 5'd0;
            r_reg_write <= 1'b0;
            r_is_store  <= 1'b0;
            r_funct3    <= 3'd0;
            r_off       <= 2'd0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_wstrb   <= 4'd0;
            wb_en       <= 1'b0;
            wb_rd       <= 5'd0;
            wb_data     <= '0;
            lsu_fault   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_rd        <= in_rd;
                        r_reg_write <= in_reg_write;
                        r_is_store  <= in_mem_write;
                        r_funct3    <= in_funct3;
                        r_off       <= in_alu_result[1:0];
                        wb_rd       <= in_rd;
                        wb_data     <= in_alu_result;
                        mem_addr    <= in_alu_result[ADDR_WIDTH-1:0];
                        mem_we      <= in_mem_write;
                        mem_wdata   <= store_wdata(in_funct3, in_store_data);
                        mem_wstrb   <= in_mem_write ? store_wstrb(in_funct3, in_alu_result[1:0]) : 4'd0;
                        if (!w_is_mem) begin
                            wb_en   <= in_reg_write && (in_rd != 5'd0);
                            r_state <= ST_WB;
                        end else if (w_fault) begin
                            // Faulting accesses skip memory entirely.
                            lsu_fault <= 1'b1;
                            r_state   <= ST_WB;
                        end else begin
                            mem_req <= 1'b1;
                            r_state <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        if (r_is_store) begin
                            r_state <= ST_WB;
                        end else if (mem_rvalid) begin
                            // Zero-wait memory: data arrives alongside the grant.
                            wb_en   <= w_load_wb_en;
                            wb_data <= w_load_data;
                            r_state <= ST_WB;
                        end else begin
                            r_state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (mem_rvalid) begin
                        wb_en   <= w_load_wb_en;
                        wb_data <= w_load_data;
                        r_state <= ST_WB;
                    end
                end
                ST_WB: begin
                    wb_en     <= 1'b0;
                    lsu_fault <= 1'b0;
                    r_state   <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22041211_lsu_wb.sv
// ----------------------------------------------------------------------------
// tb_ysyx_22041211_lsu_wb
// Directed bench for the LSU/writeback stage. A behavioural model derives the
// expected memory request, writeback and fault from the instruction fields;
// a per-cycle compare process checks the DUT against those expectations.
// ----------------------------------------------------------------------------
module tb_ysyx_22041211_lsu_wb;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_alu_result;
    logic [31:0] in_store_data;
    logic [4:0]  in_rd;
    logic        in_reg_write;
    logic        in_mem_read;
    logic        in_mem_write;
    logic [2:0]  in_funct3;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        lsu_fault;

    ysyx_22041211_lsu_wb dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_alu_result (in_alu_result),
        .in_store_data (in_store_data),
        .in_rd         (in_rd),
        .in_reg_write  (in_reg_write),
        .in_mem_read   (in_mem_read),
        .in_mem_write  (in_mem_write),
        .in_funct3     (in_funct3),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_wstrb     (mem_wstrb),
        .mem_gnt       (mem_gnt),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata),
        .wb_en         (wb_en),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .lsu_fault     (lsu_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int req_seen = 0;

    // Expected state for the compare process.
    logic        chk_en    = 1'b0;
    logic        exp_ready = 1'b0;
    logic        exp_req   = 1'b0;
    logic        exp_we    = 1'b0;
    logic [31:0] exp_addr  = '0;
    logic [31:0] exp_wdata = '0;
    logic [3:0]  exp_wstrb = '0;
    logic        exp_wb    = 1'b0;
    logic [4:0]  exp_rd    = '0;
    logic [31:0] exp_data  = '0;
    logic        exp_fault = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp_v, $time);
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic model_fault(input logic ld, input logic st,
                                         input logic [2:0] f3, input logic [31:0] addr);
        int size_bytes;
        logic ok;
        if (!ld && !st) return 1'b0;
        if (ld) ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                     (f3 == 3'b100) || (f3 == 3'b101);
        else    ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
        if (!ok) return 1'b1;
        size_bytes = 1 << int'(f3[1:0]);
        return (int'(addr[1:0]) % size_bytes) != 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] word,
                                               input logic [1:0] off, input logic [2:0] f3);
        logic [31:0] s;
        logic [7:0]  b;
        logic [15:0] h;
        s = word >> (8 * int'(off));
        b = s[7:0];
        h = s[15:0];
        case (f3)
            3'b000:  return 32'(signed'(b));
            3'b001:  return 32'(signed'(h));
            3'b100:  return 32'(b);
            3'b101:  return 32'(h);
            default: return word;
        endcase
    endfunction

    function automatic logic [31:0] model_wdata(input logic [31:0] d, input logic [2:0] f3);
        logic [31:0] r;
        r = d;
        if (f3 == 3'b000) for (int k = 0; k < 4; k++) r[8*k +: 8] = d[7:0];
        if (f3 == 3'b001) for (int k = 0; k < 2; k++) r[16*k +: 16] = d[15:0];
        return r;
    endfunction

    function automatic logic [3:0] model_wstrb(input logic [1:0] off, input logic [2:0] f3);
        logic [3:0] r;
        int nbytes;
        r = 4'd0;
        nbytes = 1 << int'(f3[1:0]);
        for (int k = 0; k < nbytes; k++) r[int'(off) + k] = 1'b1;
        return r;
    endfunction

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (mem_req) req_seen++;
        if (chk_en) begin
            check("in_ready", 32'(in_ready), 32'(exp_ready));
            check("mem_req", 32'(mem_req), 32'(exp_req));
            check("wb_en", 32'(wb_en), 32'(exp_wb));
            check("lsu_fault", 32'(lsu_fault), 32'(exp_fault));
            if (exp_req) begin
                check("mem_we", 32'(mem_we), 32'(exp_we));
                check("mem_addr", mem_addr, exp_addr);
                check("mem_wstrb", 32'(mem_wstrb), 32'(exp_wstrb));
                if (exp_we) check("mem_wdata", mem_wdata, exp_wdata);
            end
            if (exp_wb) begin
                check("wb_rd", 32'(wb_rd), 32'(exp_rd));
                check("wb_data", wb_data, exp_data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction in an idle cycle, play the memory side with the
    // given grant delay and read-data delay (0 = rvalid with the grant), and
    // set expectations cycle by cycle. EXU holds in_valid until writeback.
    task automatic run_op(input logic [31:0] alu, input logic [31:0] sdata,
                          input logic [4:0] rd, input logic rw,
                          input logic mr, input logic mw, input logic [2:0] f3,
                          input int gd, input int rvd, input logic [31:0] rdata);
        logic flt;
        int   req_base;
        flt = model_fault(mr, mw, f3, alu);
        in_valid      = 1'b1;
        in_alu_result = alu;
        in_store_data = sdata;
        in_rd         = rd;
        in_reg_write  = rw;
        in_mem_read   = mr;
        in_mem_write  = mw;
        in_funct3     = f3;
        tick();
        exp_ready = 1'b0;
        if (!(mr || mw) || flt) begin
            in_valid  = 1'b0;
            exp_wb    = !(mr || mw) && rw && (rd != 5'd0);
            exp_fault = flt;
            exp_rd    = rd;
            exp_data  = alu;
            tick();
        end else begin
            req_base  = req_seen;
            exp_req   = 1'b1;
            exp_we    = mw;
            exp_addr  = alu;
            exp_wdata = model_wdata(sdata, f3);
            exp_wstrb = mw ? model_wstrb(alu[1:0], f3) : 4'd0;
            for (int g = 0; g <= gd; g++) begin
                if (g == gd) begin
                    mem_gnt = 1'b1;
                    if (mr && rvd == 0) begin
                        mem_rvalid = 1'b1;
                        mem_rdata  = rdata;
                    end
                end
                tick();
            end
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            mem_rdata  = 32'h5A5A_5A5A;
            exp_req    = 1'b0;
            if (mr && rvd > 0) begin
                for (int w = 1; w <= rvd; w++) begin
                    if (w == rvd) begin
                        mem_rvalid = 1'b1;
                        mem_rdata  = rdata;
                    end
                    tick();
                end
                mem_rvalid = 1'b0;
                mem_rdata  = 32'h5A5A_5A5A;
            end
            in_valid = 1'b0;
            exp_wb   = mr && rw && (rd != 5'd0);
            exp_rd   = rd;
            exp_data = model_load(rdata, alu[1:0], f3);
            tick();
            check("req_cycles", 32'(req_seen - req_base), 32'(gd + 1));
        end
        exp_wb    = 1'b0;
        exp_fault = 1'b0;
        exp_ready = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        in_valid      = 1'b0;
        in_alu_result = '0;
        in_store_data = '0;
        in_rd         = '0;
        in_reg_write  = 1'b0;
        in_mem_read   = 1'b0;
        in_mem_write  = 1'b0;
        in_funct3     = '0;
        mem_gnt       = 1'b0;
        mem_rvalid    = 1'b0;
        mem_rdata     = 32'h5A5A_5A5A;

        // Model pins: hand-computed literals.
        check("pin_lb", model_load(32'h80FF_0000, 2'd3, 3'b000), 32'hFFFF_FF80);
        check("pin_lbu", model_load(32'h80FF_0000, 2'd3, 3'b100), 32'h0000_0080);
        check("pin_lh", model_load(32'h8765_1234, 2'd2, 3'b001), 32'hFFFF_8765);
        check("pin_lhu", model_load(32'h8765_1234, 2'd2, 3'b101), 32'h0000_8765);
        check("pin_sh_wdata", model_wdata(32'hAAAA_BEEF, 3'b001), 32'hBEEF_BEEF);
        check("pin_sh_wstrb", 32'(model_wstrb(2'd2, 3'b001)), 32'h0000_000C);
        check("pin_sb_wstrb", 32'(model_wstrb(2'd1, 3'b000)), 32'h0000_0002);
        check("pin_lw_fault", 32'(model_fault(1'b1, 1'b0, 3'b010, 32'h8000_0006)), 32'd1);
        check("pin_ld011_fault", 32'(model_fault(1'b1, 1'b0, 3'b011, 32'h8000_0000)), 32'd1);

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_wb_en", 32'(wb_en), 32'd0);
        check("rst_lsu_fault", 32'(lsu_fault), 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
        rst       = 1'b0;
        exp_ready = 1'b1;
        chk_en    = 1'b1;
        tick();

        //      alu            sdata          rd  rw  mr  mw  f3      gd rvd rdata
        run_op(32'h1234_5678, 32'h0,         5,  1,  0,  0,  3'b000, 0, 0, 32'h0);
        run_op(32'h8000_0003, 32'h0,         1,  1,  1,  0,  3'b000, 0, 1, 32'h80FF_0000);
        run_op(32'h8000_0003, 32'h0,         2,  1,  1,  0,  3'b100, 0, 1, 32'h80FF_0000);
        run_op(32'h8000_0002, 32'hAAAA_BEEF, 0,  0,  0,  1,  3'b001, 3, 0, 32'h0);
        run_op(32'h8000_0006, 32'h0,         4,  1,  1,  0,  3'b010, 0, 0, 32'h0);
        run_op(32'h8000_0008, 32'h0,         0,  1,  1,  0,  3'b010, 1, 0, 32'hDEAD_BEEF);
        run_op(32'h8000_000C, 32'h0,         3,  1,  1,  0,  3'b010, 0, 0, 32'h0BAD_F00D);
        run_op(32'h8000_0012, 32'h0,         8,  1,  1,  0,  3'b001, 0, 2, 32'h8765_1234);
        run_op(32'h8000_0012, 32'h0,         9,  1,  1,  0,  3'b101, 2, 1, 32'h8765_1234);
        run_op(32'h8000_0001, 32'h1234_56A5, 10, 1,  0,  1,  3'b000, 1, 0, 32'h0);
        run_op(32'h8000_0004, 32'hCAFE_BABE, 11, 1,  0,  1,  3'b010, 0, 0, 32'h0);
        run_op(32'h8000_0000, 32'h0,         12, 1,  1,  0,  3'b011, 0, 0, 32'h0);
        run_op(32'h8000_0000, 32'h1111_1111, 13, 0,  0,  1,  3'b100, 0, 0, 32'h0);
        run_op(32'h0000_0042, 32'h0,         0,  1,  0,  0,  3'b000, 0, 0, 32'h0);
        run_op(32'h0000_0043, 32'h0,         7,  0,  0,  0,  3'b000, 0, 0, 32'h0);
        run_op(32'h8000_0020, 32'h0,         14, 1,  1,  0,  3'b000, 0, 0, 32'h1234_567F);

        // Stray grant and read data while idle are ignored.
        mem_gnt    = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hFFFF_FFFF;
        tick();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h5A5A_5A5A;

        // Reset while a request is pending: mem_req drops without a clock edge.
        in_valid      = 1'b1;
        in_alu_result = 32'h8000_0020;
        in_rd         = 5'd9;
        in_reg_write  = 1'b1;
        in_mem_read   = 1'b1;
        in_mem_write  = 1'b0;
        in_funct3     = 3'b010;
        tick();
        exp_ready = 1'b0;
        exp_req   = 1'b1;
        exp_we    = 1'b0;
        exp_addr  = 32'h8000_0020;
        exp_wstrb = 4'd0;
        tick();
        chk_en = 1'b0;
        rst    = 1'b1;
        #1;
        check("async_req_drop", 32'(mem_req), 32'd0);
        check("rst_ready_low", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        exp_req  = 1'b0;
        chk_en   = 1'b1;
        tick();
        rst       = 1'b0;
        exp_ready = 1'b1;
        tick();

        // Reset while waiting for load data, then late rvalid is discarded.
        in_valid      = 1'b1;
        in_alu_result = 32'h8000_0010;
        in_rd         = 5'd7;
        tick();
        exp_ready = 1'b0;
        exp_req   = 1'b1;
        exp_addr  = 32'h8000_0010;
        mem_gnt   = 1'b1;
        tick();
        mem_gnt = 1'b0;
        exp_req = 1'b0;
        tick();
        rst      = 1'b1;
        in_valid = 1'b0;
        tick();
        rst       = 1'b0;
        exp_ready = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1111_2222;
        tick();
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h5A5A_5A5A;

        run_op(32'hCAFE_F00D, 32'h0, 6, 1, 0, 0, 3'b000, 0, 0, 32'h0);
        tick();

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
